// File: rtl/cevero_obi_ram.sv
// Shared single-port SRAM with NUM_PORTS OBI-style requestors, round-robin
// arbitrated. One transfer is accepted per cycle and its response returns
// exactly LATENCY cycles later through a fixed, non-stalling pipeline.
module cevero_obi_ram #(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_PORTS-1:0]               req_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]               we_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_PORTS-1:0]               err_o
);

  localparam int NUM_BE = DATA_WIDTH / 8;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  // Response payload travelling down the latency pipeline.
  typedef struct packed {
    logic [PTR_W-1:0]      port;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      cand;
  logic                  sel_valid;
  logic [PTR_W-1:0]      sel_port;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] sel_off;
  logic                  sel_we;
  logic [NUM_BE-1:0]     sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_err;
  logic [IDX_W-1:0]      sel_idx;
  resp_t                 resp_d;

  logic [DATA_WIDTH-1:0] mem_q        [NUM_WORDS];
  logic                  pipe_valid_q [LATENCY];
  resp_t                 pipe_q       [LATENCY];

  // Round-robin arbiter: scan upward from ptr_q, first requestor wins.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt_o     = '0;
    sel_valid = 1'b0;
    sel_port  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
      if (!sel_valid && req_i[cand]) begin
        sel_valid = 1'b1;
        sel_port  = cand;
      end
    end
    // No grant may escape while reset is held, so nothing is written then.
    if (!rst_ni) begin
      sel_valid = 1'b0;
    end
    if (sel_valid) begin
      gnt_o[sel_port] = 1'b1;
    end
    ptr_d = ptr_q;
    if (sel_valid) begin
      ptr_d = PTR_W'((int'(sel_port) + 1) % NUM_PORTS);
    end
  end

  // Mux the granted port's request and decode it against the mapped window.
  always_comb begin
    sel_addr  = addr_i[int'(sel_port)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_we    = we_i[sel_port];
    sel_be    = be_i[int'(sel_port)*NUM_BE +: NUM_BE];
    sel_wdata = wdata_i[int'(sel_port)*DATA_WIDTH +: DATA_WIDTH];
    // Addresses below BASE_ADDR wrap to a huge offset and land in the error range.
    sel_off   = sel_addr - BASE_ADDR;
    sel_err   = (sel_off >> 2) >= ADDR_WIDTH'(NUM_WORDS);
    sel_idx   = sel_off[IDX_W+1:2];
    resp_d.port = sel_port;
    resp_d.err  = sel_err;
    resp_d.data = (sel_we || sel_err) ? '0 : mem_q[sel_idx];
  end

  // Byte-lane write of the array at the grant edge.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; its contents are meant to survive
    // rst_ni, and resetting it would forbid mapping it onto an SRAM macro.
    if (sel_valid && sel_we && !sel_err) begin
      for (int b = 0; b < NUM_BE; b++) begin
        if (sel_be[b]) begin
          mem_q[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  // Arbitration pointer and response valid bits; reset drops in-flight responses.
  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_valid_q[s] <= 1'b0;
      end
    end else begin
      ptr_q           <= ptr_d;
      pipe_valid_q[0] <= sel_valid;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
      end
    end
  end

  // Response payload shift; qualified by the valid bits, so left unreset.
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= resp_d;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  // Steer the last pipeline stage to its requestor; all other ports read zero.
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (pipe_valid_q[LATENCY-1]) begin
      rvalid_o[pipe_q[LATENCY-1].port] = 1'b1;
      err_o[pipe_q[LATENCY-1].port]    = pipe_q[LATENCY-1].err;
      rdata_o[int'(pipe_q[LATENCY-1].port)*DATA_WIDTH +: DATA_WIDTH] = pipe_q[LATENCY-1].data;
    end
  end

endmodule
